// File: rtl/uop_fetch_queue.sv
// Multi-lane uop fetch queue between decode and the backend instr_queue (circular buffer).
// Latency: an entry written in cycle N is visible on the deq outputs in cycle N+1 (no bypass).
// Backpressure: enq_ready_out drops when fewer than LANES slots are free (registered count only);
//               the whole deq group is popped when deq_ready_in is high.
// Ports: clk_in/rst_in (async active-high), enq_valid_in/enq_uops_in/enq_ready_out,
//        deq_uops_out/deq_valid_out/deq_ready_in, flush_in, count_out,
//        flush_cnt_out/full_stall_cnt_out.
// Optional: define UOP_FETCH_QUEUE_STATS_EN to build the saturating statistic counters;
//           without it both counter outputs read 0 and no counter flops exist.

package uop_pkg;
    localparam int INSTR_Q_WIDTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } uop_insn;
endpackage

module uop_fetch_queue #(
    parameter int DEPTH = 16,
    parameter int LANES = uop_pkg::INSTR_Q_WIDTH
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic [LANES-1:0]                  enq_valid_in,
    input  uop_pkg::uop_insn [LANES-1:0]      enq_uops_in,
    output logic                              enq_ready_out,
    output uop_pkg::uop_insn [LANES-1:0]      deq_uops_out,
    output logic [LANES-1:0]                  deq_valid_out,
    input  logic                              deq_ready_in,
    input  logic                              flush_in,
    output logic [$clog2(DEPTH+1)-1:0]        count_out,
    output logic [31:0]                       flush_cnt_out,
    output logic [31:0]                       full_stall_cnt_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int LW = $clog2(LANES+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LANES_C = CW'(LANES);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t            state_q;
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     count_q;

    // Entry storage is deliberately not reset; validity comes only from count_q.
    uop_pkg::uop_insn  mem [DEPTH];

    logic              contig;
    logic [LW-1:0]     enq_n;
    logic [LW-1:0]     deq_n;
    logic              enq_fire;
    logic              deq_fire;

    always_comb begin
        // A contiguous-from-lane-0 mask is of the form 0..01..1, so v & (v+1) is zero.
        contig = ((enq_valid_in & (enq_valid_in + LANES'(1))) == '0);

        enq_n = '0;
        for (int i = 0; i < LANES; i++) begin
            enq_n = enq_n + LW'(enq_valid_in[i]);
        end

        enq_ready_out = (state_q == RUN) && ((DEPTH_C - count_q) >= LANES_C);

        for (int i = 0; i < LANES; i++) begin
            deq_valid_out[i] = (state_q == RUN) && (count_q > CW'(i));
            deq_uops_out[i]  = mem[head_q + PW'(i)];
        end

        deq_n = (count_q >= LANES_C) ? LW'(LANES) : LW'(count_q);

        // A flush discards anything offered in the same cycle in either direction.
        enq_fire = enq_ready_out && (|enq_valid_in) && contig && !flush_in;
        deq_fire = deq_ready_in && deq_valid_out[0] && !flush_in;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_in) begin
            state_q <= FLUSH;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= RUN;
            if (enq_fire) begin
                tail_q <= tail_q + PW'(enq_n);
            end
            if (deq_fire) begin
                head_q <= head_q + PW'(deq_n);
            end
            count_q <= count_q + (enq_fire ? CW'(enq_n) : '0) - (deq_fire ? CW'(deq_n) : '0);
        end
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < LANES; i++) begin
            if (enq_fire && enq_valid_in[i]) begin
                mem[tail_q + PW'(i)] <= enq_uops_in[i];
            end
        end
    end

    assign count_out = count_q;

`ifdef UOP_FETCH_QUEUE_STATS_EN
    logic [31:0] flush_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if ((state_q == RUN) && flush_in && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
            if (!enq_ready_out && (|enq_valid_in) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign flush_cnt_out      = flush_cnt_q;
    assign full_stall_cnt_out = stall_cnt_q;
`else
    assign flush_cnt_out      = '0;
    assign full_stall_cnt_out = '0;
`endif

endmodule

// File: tb/tb_uop_fetch_queue.sv
// Directed bench for uop_fetch_queue (DEPTH=16, LANES=4) with a pc scoreboard.
// Stimulus pushes the pcs it expects to be accepted; a negedge monitor pops on every dequeue.
// Status outputs (count, ready, valid, counters) are checked at hand-computed points.

module tb_uop_fetch_queue;

    logic                         clk_in;
    logic                         rst_in;
    logic [3:0]                   enq_valid_in;
    uop_pkg::uop_insn [3:0]       enq_uops_in;
    logic                         enq_ready_out;
    uop_pkg::uop_insn [3:0]       deq_uops_out;
    logic [3:0]                   deq_valid_out;
    logic                         deq_ready_in;
    logic                         flush_in;
    logic [4:0]                   count_out;
    logic [31:0]                  flush_cnt_out;
    logic [31:0]                  full_stall_cnt_out;

    int checks;
    int failures;
    logic [31:0] exp_q[$];

`ifdef UOP_FETCH_QUEUE_STATS_EN
    localparam logic [31:0] STALL_EXP = 32'd1;
    localparam logic [31:0] FLUSH_EXP = 32'd1;
`else
    localparam logic [31:0] STALL_EXP = 32'd0;
    localparam logic [31:0] FLUSH_EXP = 32'd0;
`endif

    uop_fetch_queue #(.DEPTH(16), .LANES(4)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .enq_valid_in       (enq_valid_in),
        .enq_uops_in        (enq_uops_in),
        .enq_ready_out      (enq_ready_out),
        .deq_uops_out       (deq_uops_out),
        .deq_valid_out      (deq_valid_out),
        .deq_ready_in       (deq_ready_in),
        .flush_in           (flush_in),
        .count_out          (count_out),
        .flush_cnt_out      (flush_cnt_out),
        .full_stall_cnt_out (full_stall_cnt_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Drive one fetch group for a single cycle; lane i carries pc0 + 4*i.
    task automatic drive_group(input logic [3:0] v, input logic [31:0] pc0, input bit accept);
        enq_valid_in = v;
        for (int i = 0; i < 4; i++) begin
            enq_uops_in[i].pc   = pc0 + 32'(4 * i);
            enq_uops_in[i].insn = (pc0 + 32'(4 * i)) ^ 32'hA5A5_0000;
            if (accept && v[i]) exp_q.push_back(pc0 + 32'(4 * i));
        end
    endtask

    task automatic enq_group(input logic [3:0] v, input logic [31:0] pc0, input bit accept);
        drive_group(v, pc0, accept);
        step();
        enq_valid_in = 4'b0000;
    endtask

    // Monitor: every lane presented while the backend is ready must match the scoreboard head.
    always @(negedge clk_in) begin
        if (!rst_in && !flush_in && deq_ready_in && deq_valid_out[0]) begin
            for (int i = 0; i < 4; i++) begin
                if (deq_valid_out[i]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL deq_extra lane%0d: got pc 0x%0h expected no entry", i, deq_uops_out[i].pc);
                    end else begin
                        logic [31:0] e;
                        e = exp_q.pop_front();
                        if (deq_uops_out[i].pc !== e || deq_uops_out[i].insn !== (e ^ 32'hA5A5_0000)) begin
                            failures++;
                            $display("FAIL deq_pc lane%0d: got pc 0x%0h insn 0x%0h expected pc 0x%0h", i,
                                     deq_uops_out[i].pc, deq_uops_out[i].insn, e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        checks       = 0;
        failures     = 0;
        rst_in       = 1'b0;
        enq_valid_in = 4'b0000;
        enq_uops_in  = '0;
        deq_ready_in = 1'b0;
        flush_in     = 1'b0;

        // Reset state is visible without any clock edge.
        #1 rst_in = 1'b1;
        #1;
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_enq_ready", 32'(enq_ready_out), 32'd1);
        chk("rst_deq_valid", 32'(deq_valid_out), 32'd0);
        chk("rst_flush_cnt", flush_cnt_out, 32'd0);
        chk("rst_stall_cnt", full_stall_cnt_out, 32'd0);
        step();
        step();
        rst_in = 1'b0;

        // One group of 4: visible the next cycle.
        enq_group(4'b1111, 32'h0, 1'b1);
        chk("first_deq_valid", 32'(deq_valid_out), 32'hF);
        chk("first_lane0_pc", deq_uops_out[0].pc, 32'h0);
        chk("first_count", 32'(count_out), 32'd4);

        // Fill to 16; the 5th group must be dropped and counted as a stall cycle.
        enq_group(4'b1111, 32'h10, 1'b1);
        enq_group(4'b1111, 32'h20, 1'b1);
        enq_group(4'b1111, 32'h30, 1'b1);
        chk("full_count", 32'(count_out), 32'd16);
        chk("full_enq_ready", 32'(enq_ready_out), 32'd0);
        enq_group(4'b1111, 32'h40, 1'b0);
        chk("full_count_after_drop", 32'(count_out), 32'd16);
        chk("full_stall_cnt", full_stall_cnt_out, STALL_EXP);

        // Drain in four pops.
        deq_ready_in = 1'b1;
        for (int k = 0; k < 4; k++) step();
        deq_ready_in = 1'b0;
        chk("drain_count", 32'(count_out), 32'd0);
        chk("drain_enq_ready", 32'(enq_ready_out), 32'd1);

        // Partial group of two.
        enq_group(4'b0011, 32'h100, 1'b1);
        chk("partial_deq_valid", 32'(deq_valid_out), 32'h3);
        chk("partial_count", 32'(count_out), 32'd2);
        deq_ready_in = 1'b1;
        step();
        deq_ready_in = 1'b0;
        chk("partial_pop_count", 32'(count_out), 32'd0);
        chk("partial_pop_valid", 32'(deq_valid_out), 32'd0);

        // Non-contiguous mask is ignored.
        enq_group(4'b0101, 32'h200, 1'b0);
        chk("noncontig_count", 32'(count_out), 32'd0);
        chk("noncontig_stall_cnt", full_stall_cnt_out, STALL_EXP);

        // Steady state at count 4 for 40 cycles: pointers wrap many times.
        enq_group(4'b1111, 32'h1000, 1'b1);
        deq_ready_in = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            drive_group(4'b1111, 32'h1000 + 32'(16 * k), 1'b1);
            step();
            if (k == 20 || k == 40) chk("wrap_count", 32'(count_out), 32'd4);
        end
        enq_valid_in = 4'b0000;
        step();
        deq_ready_in = 1'b0;
        chk("wrap_drain_count", 32'(count_out), 32'd0);

        // Fill 12, then flush together with an enqueue and a pop request.
        enq_group(4'b1111, 32'h3000, 1'b1);
        enq_group(4'b1111, 32'h3010, 1'b1);
        enq_group(4'b1111, 32'h3020, 1'b1);
        chk("preflush_count", 32'(count_out), 32'd12);
        exp_q.delete();
        flush_in     = 1'b1;
        deq_ready_in = 1'b1;
        drive_group(4'b1111, 32'h3030, 1'b0);
        step();
        flush_in     = 1'b0;
        deq_ready_in = 1'b0;
        enq_valid_in = 4'b0000;
        chk("flush_count", 32'(count_out), 32'd0);
        chk("flush_enq_ready", 32'(enq_ready_out), 32'd0);
        chk("flush_deq_valid", 32'(deq_valid_out), 32'd0);
        step();
        chk("postflush_enq_ready", 32'(enq_ready_out), 32'd1);
        chk("postflush_count", 32'(count_out), 32'd0);
        chk("flush_cnt", flush_cnt_out, FLUSH_EXP);

        // Queue still works after the flush.
        enq_group(4'b0111, 32'h4000, 1'b1);
        chk("postflush_deq_valid", 32'(deq_valid_out), 32'h7);
        deq_ready_in = 1'b1;
        step();
        deq_ready_in = 1'b0;

        // Asynchronous reset mid-cycle with 8 entries queued.
        enq_group(4'b1111, 32'h5000, 1'b1);
        enq_group(4'b1111, 32'h5010, 1'b1);
        chk("prereset_count", 32'(count_out), 32'd8);
        #2 rst_in = 1'b1;
        #1;
        exp_q.delete();
        chk("async_rst_deq_valid", 32'(deq_valid_out), 32'd0);
        chk("async_rst_count", 32'(count_out), 32'd0);
        chk("async_rst_enq_ready", 32'(enq_ready_out), 32'd1);
        chk("async_rst_flush_cnt", flush_cnt_out, 32'd0);
        step();
        rst_in = 1'b0;

        // Fresh data after reset comes out alone, nothing stale.
        enq_group(4'b1111, 32'h6000, 1'b1);
        chk("postrst_count", 32'(count_out), 32'd4);
        deq_ready_in = 1'b1;
        step();
        deq_ready_in = 1'b0;
        step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
